// File: rtl/avalon_pio_edge_in_if.sv
// Avalon-MM slave register port shared by the PIO blocks: 2-bit word address,
// active-low write strobe, zero-wait-state combinational read data.
interface avalon_pio_edge_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/avalon_pio_edge_in.sv
// Input PIO: two-flop sync, per-bit debounce, sticky edge capture with W1C,
// and a registered maskable level IRQ. Map: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE.
module avalon_pio_edge_in #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_pio_edge_in_if.slave   bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2, filt, filt_nxt;
  logic [WIDTH-1:0] edge_cap, edge_evt, irq_mask, clr_mask;
  logic [WIDTH-1:0] rise, fall;
  logic [CW-1:0]    cnt [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;

  // A bit only changes after s2 has disagreed with it for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    filt_nxt = filt;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != filt[i]) begin
        if (cnt[i] == CNT_LAST) filt_nxt[i] = s2[i];
        else                    cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_comb begin
    rise = filt_nxt & ~filt;
    fall = filt & ~filt_nxt;
    if (EDGE_TYPE == 0)      edge_evt = rise;
    else if (EDGE_TYPE == 1) edge_evt = fall;
    else                     edge_evt = rise | fall;
  end

  assign wr_en    = bus.chipselect && !bus.write_n;
  assign clr_mask = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1       <= '0;
      s2       <= '0;
      filt     <= '0;
      cnt      <= '{default: '0};
      edge_cap <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      s1       <= in_port;
      s2       <= s1;
      filt     <= filt_nxt;
      cnt      <= cnt_nxt;
      // New events are OR-ed in after the clear so a same-edge set survives.
      edge_cap <= (edge_cap & ~clr_mask) | edge_evt;
      if (wr_en && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
      irq      <= |(edge_cap & irq_mask);
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata = 32'(filt);
      2'd2:    bus.readdata = 32'(irq_mask);
      2'd3:    bus.readdata = 32'(edge_cap);
      default: bus.readdata = '0;
    endcase
  end

endmodule
